// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus controller.
// Holds the bus-cycle state enum and the default bus widths.
package io_bus_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 16;
    localparam logic [2:0] WAIT_CNT_MAX  = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        TW   = 3'd4,
        T4   = 3'd5
    } bus_state_t;

endpackage

// File: rtl/io_int_sync.sv
// Brings the asynchronous active-low interrupt into the clock domain.
// Flags a one-cycle pulse on each synchronised falling edge.
module io_int_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic int_n_i,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // All flops rest high so a released line never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= int_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_o = prev_q & ~sync2_q;

endmodule

// File: rtl/io_bus_controller.sv
// 8080-style IO bus cycle engine: T1/T2/T3/TW/T4 sequencing with wait states,
// io_ready stretching and a sticky synchronised interrupt flag.
module io_bus_controller
    import io_bus_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int WAIT_STATES   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    // Request side: a request transfers when req_valid && req_ready, which
    // only happens in IDLE; rsp_valid pulses once per completed bus cycle.
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [ADDRESS_WIDTH-1:0] io_addr,
    output logic [DATA_WIDTH-1:0]    io_wdata,
    input  logic [DATA_WIDTH-1:0]    io_rdata,
    output logic                     rd_n,
    output logic                     wr_n,
    output logic                     ale,
    input  logic                     io_ready,
    input  logic                     int_n,
    input  logic                     irq_ack,
    output logic                     irq_pending,
    output bus_state_t               state
);

    localparam logic [3:0] WAIT_STATES_L = 4'(WAIT_STATES);

    bus_state_t              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     write_q;
    logic [2:0]               wait_cnt_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     irq_q;
    logic                     int_fall;
    logic                     accept;
    logic                     strobe_phase;
    logic                     addr_phase;
    logic [3:0]               waits_seen;
    logic                     waits_done;
    logic                     exit_wait;

    io_int_sync u_int_sync (
        .clk_i   (clk),
        .rst_i   (rst),
        .int_n_i (int_n),
        .fall_o  (int_fall)
    );

    assign accept = req_valid && (state_q == IDLE);

    // Count the current TW cycle too, so WAIT_STATES TW cycles are spent
    // before the exit check can pass.
    assign waits_seen = (state_q == TW) ? ({1'b0, wait_cnt_q} + 4'd1) : {1'b0, wait_cnt_q};
    assign waits_done = (waits_seen >= WAIT_STATES_L);
    assign exit_wait  = ((state_q == T3) || (state_q == TW)) && waits_done && io_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = T1;
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3, TW:  state_d = exit_wait ? T4 : TW;
            T4:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            wait_cnt_q <= 3'd0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
            end
            if (state_q == T2) begin
                wait_cnt_q <= 3'd0;
            end else if ((state_q == TW) && (wait_cnt_q != WAIT_CNT_MAX)) begin
                wait_cnt_q <= wait_cnt_q + 3'd1;
            end
            if (exit_wait) begin
                rdata_q <= write_q ? '0 : io_rdata;
            end
            // A new edge wins over a simultaneous acknowledge.
            if (int_fall) begin
                irq_q <= 1'b1;
            end else if (irq_ack) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign strobe_phase = (state_q == T2) || (state_q == T3) || (state_q == TW);
    assign addr_phase   = (state_q != IDLE);

    assign state       = state_q;
    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == T4);
    assign rsp_rdata   = rdata_q;
    assign io_addr     = addr_q;
    assign io_wdata    = (write_q && addr_phase) ? wdata_q : '0;
    assign ale         = (state_q == T1);
    assign rd_n        = ~(strobe_phase && !write_q);
    assign wr_n        = ~(strobe_phase && write_q);
    assign irq_pending = irq_q;

endmodule

// File: tb/tb_io_bus_controller.sv
// Self-checking bench for io_bus_controller: directed bus cycles, randomized
// traffic against a cycle-position reference model, reset abort and interrupts.
module tb_io_bus_controller;
  import io_bus_pkg::*;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata = '0;
  logic        rd_n;
  logic        wr_n;
  logic        ale;
  logic        io_ready = 1'b1;
  logic        int_n = 1'b1;
  logic        irq_ack = 1'b0;
  logic        irq_pending;
  bus_state_t  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_rdata = '0;
  logic [7:0]  exp_q[$];

  io_bus_controller #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(16), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .rd_n(rd_n), .wr_n(wr_n), .ale(ale), .io_ready(io_ready),
    .int_n(int_n), .irq_ack(irq_ack), .irq_pending(irq_pending),
    .state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // One bus cycle. Cycle c=0 is the IDLE acceptance cycle; the model places
  // T1 at c=1, T2 at c=2, the wait phase at c=3..3+k (k = first wait index
  // that is >= WS with io_ready high) and the completion at c=4+k.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [15:0] ready_mask, input logic fixed_rd,
                         input logic [7:0] rd_val, input logic hold_valid);
    int k_exit;
    int last;
    logic [15:0] mask;
    logic [7:0]  rd_now;
    logic [7:0]  exp_r;
    logic [36:0] exp_v;
    logic [36:0] obs_v;
    mask = ready_mask | 16'h8000;
    k_exit = WS;
    while (k_exit < 15 && !mask[k_exit]) k_exit++;
    last = 4 + k_exit;
    exp_r = last_rdata;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == last) exp_r = exp_q.pop_front();
      exp_v = {c == 1,
               !(!wr && c >= 2 && c <= 3 + k_exit),
               !(wr && c >= 2 && c <= 3 + k_exit),
               c == last, c == 0,
               (c == 0) ? last_addr : addr,
               (wr && c >= 1) ? wd : 8'h00,
               exp_r};
      obs_v = {ale, rd_n, wr_n, rsp_valid, req_ready, io_addr, io_wdata, rsp_rdata};
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL bus_cycle c=%0d wr=%0b {ale,rd_n,wr_n,rsp_valid,req_ready,addr,wdata,rdata} got %h required %h",
                 c, wr, obs_v, exp_v);
      end
      if (c == 0) begin
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      end else begin
        req_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
        if (c == last && !hold_valid) req_valid = 1'b0;
      end
      rd_now   = fixed_rd ? rd_val : 8'($urandom);
      io_rdata = rd_now;
      io_ready = (c >= 3 && c <= 3 + k_exit) ? mask[c-3] : 1'($urandom_range(0, 1));
      if (c == 3 + k_exit) exp_q.push_back(wr ? 8'h00 : rd_now);
    end
    last_addr  = addr;
    last_rdata = exp_r;
  endtask

  task automatic test_reset();
    logic [36:0] obs_v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs_v = {ale, rd_n, wr_n, rsp_valid, req_ready, io_addr, io_wdata, rsp_rdata};
    n_vec++;
    if (obs_v !== {5'b01101, 16'h0000, 8'h00, 8'h00} || dbg_state !== IDLE || irq_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values got %h state=%0d irq=%0b required %h state=0 irq=0",
               obs_v, dbg_state, irq_pending, {5'b01101, 16'h0000, 8'h00, 8'h00});
    end
    rst = 1'b0;
    last_addr = '0;
    last_rdata = '0;
  endtask

  task automatic test_read();
    run_txn(1'b0, 16'hFF05, 8'h00, 16'hFFFF, 1'b1, 8'hA5, 1'b0);
    n_vec++;
    if (last_rdata !== 8'hA5 || rsp_rdata !== 8'hA5) begin
      n_err++;
      $display("FAIL read_data got %h required a5", rsp_rdata);
    end
  endtask

  task automatic test_write();
    run_txn(1'b1, 16'h1C80, 8'h3C, 16'hFFFF, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_vec++;
    if (io_wdata !== 8'h00 || rsp_rdata !== 8'h00 || wr_n !== 1'b1) begin
      n_err++;
      $display("FAIL write_idle io_wdata=%h rsp_rdata=%h wr_n=%0b required 00 00 1",
               io_wdata, rsp_rdata, wr_n);
    end
  endtask

  task automatic test_io_ready();
    // io_ready low in T3 and the first three TW cycles: three extra TW, latency 8.
    run_txn(1'b0, 16'h4321, 8'h00, 16'hFFF0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 16'($urandom), 8'($urandom), 16'hFFFF, 1'b0, 8'h00, 1'b1);
    run_txn(1'b1, 16'($urandom), 8'($urandom), 16'hFFFF, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
              16'($urandom) | 16'($urandom), 1'b0, 8'h00,
              (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234; io_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (rd_n !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_in_wait rd_n=%0b rsp_valid=%0b required 0 0", rd_n, rsp_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    io_ready = 1'b1;
    n_vec++;
    if (rd_n !== 1'b1 || wr_n !== 1'b1 || dbg_state !== IDLE || req_ready !== 1'b1 ||
        rsp_valid !== 1'b0 || io_addr !== 16'h0000 || rsp_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL abort_state rd_n=%0b state=%0d req_ready=%0b rsp_valid=%0b io_addr=%h required 1 0 1 0 0000",
               rd_n, dbg_state, req_ready, rsp_valid, io_addr);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0 || dbg_state !== IDLE) begin
        n_err++;
        $display("FAIL abort_quiet i=%0d rsp_valid=%0b state=%0d required 0 0", i, rsp_valid, dbg_state);
      end
    end
    last_addr = '0;
    last_rdata = '0;
  endtask

  task automatic test_interrupt();
    int seen;
    @(negedge clk);
    int_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 3 && seen == 0; i++) begin
      @(negedge clk);
      if (irq_pending === 1'b1) seen = i + 1;
    end
    n_vec++;
    if (seen == 0) begin
      n_err++;
      $display("FAIL irq_set irq_pending=%0b after 3 cycles, required 1", irq_pending);
    end
    repeat ($urandom_range(2, 5)) @(negedge clk);
    int_n = 1'b1;
    repeat ($urandom_range(4, 7)) @(negedge clk);
    n_vec++;
    if (irq_pending !== 1'b1) begin
      n_err++;
      $display("FAIL irq_sticky got %0b required 1", irq_pending);
    end
    // Second falling edge; its synchronised edge lands on the ack cycle.
    int_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    n_vec++;
    if (irq_pending !== 1'b1) begin
      n_err++;
      $display("FAIL irq_ack_with_edge got %0b required 1", irq_pending);
    end
    repeat ($urandom_range(1, 4)) @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    n_vec++;
    if (irq_pending !== 1'b0) begin
      n_err++;
      $display("FAIL irq_lone_ack got %0b required 0", irq_pending);
    end
    int_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (irq_pending !== 1'b0) begin
      n_err++;
      $display("FAIL irq_rising_edge got %0b required 0", irq_pending);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_io_ready();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_read();
    test_interrupt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
